ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the RV32I pipeline; sits directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code, operands and forwarded control bits from ID/EX.
- Computes the ALU result, zero flag and branch decision.
- Holds everything in the EX/MEM pipeline register behind a valid/ready handshake, with flush support.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ID/EX beat valid.
- in_ready  out  1  stage can accept a beat.
- alu_ctrl  in  4  ALU control code from the ALU control decoder.
- op_a  in  XLEN  operand A.
- op_b  in  XLEN  operand B (register or immediate, already muxed).
- store_data_in  in  XLEN  rs2 value for stores.
- rd_in  in  RA_W  destination register.
- reg_write_in, mem_read_in, mem_write_in  in  1 each  control passthrough.
- branch_in  in  1  instruction is beq/bne.
- branch_ne_in  in  1  1 = bne, 0 = beq.
- flush  in  1  kill all held and incoming beats.
- out_valid  out  1  EX/MEM beat valid.
- out_ready  in  1  downstream accepts.
- result  out  XLEN  ALU result.
- zero  out  1  result == 0.
- branch_taken  out  1  resolved branch.
- store_data, rd, reg_write, mem_read, mem_write  out  registered passthroughs.

Behaviour:
- Reset is asynchronous, on rst_n low. All outputs and held state clear to 0; in_ready reads 1 after reset.
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- ALU decode, combinational on the inputs:
  - 0000 add, 1000 sub (both wrap mod 2^XLEN).
  - 0001 sll, 0101 srl, 1101 sra; shift amount is op_b[4:0].
  - 0010 slt (signed, result 0 or 1), 0011 sltu (unsigned, result 0 or 1).
  - 0100 xor, 0110 or, 0111 and.
  - Any other code gives result 0.
- zero = (alu result == 0).
- branch_taken = branch_in & (zero ^ branch_ne_in). All outputs are registered.
- Latency: 1 cycle from accepted beat to out_valid.
- Transfer in: in_valid & in_ready at the clock edge.
- Transfer out: out_valid & out_ready at the clock edge.
- in_ready = !out_valid | out_ready. This is a combinational path from out_ready.
- Stall: while out_valid & !out_ready, all output registers hold and no new beat is accepted.
- Simultaneous accept and drain: the register loads the new beat and out_valid stays 1, giving full throughput of one beat per cycle.
- No input while draining: out_valid goes to 0 on the next cycle.
- Flush:
  - Has priority over everything. On the next edge out_valid = 0, and any beat offered in that cycle is dropped.
  - Data registers may hold stale values; reg_write, mem_read, mem_write and branch_taken are cleared so stale control is never exposed.
- rst_n asserted mid-stall drops everything immediately, with no pending beat surviving.
- Data and control fields are ignored when in_valid = 0.

Optional Feature:
- EX_SKID_EN defined:
  - Adds a one-entry skid buffer, and in_ready becomes a registered signal: in_ready = !skid_valid.
  - A beat accepted while the output is stalled goes into the skid. When out_ready returns, the skid moves to the output register, and in_ready returns to 1 on the next cycle.
  - Beat order is preserved. Flush clears both entries.
  - Throughput stays one beat per cycle, and no combinational path from out_ready to in_ready exists.
- EX_SKID_EN undefined: single output register and combinational in_ready exactly as above.

Decomposition:
- Shared package riscv_pkg holds:
  - ALU control localparams ALU_ADD=4'b0000, ALU_SUB=4'b1000, ALU_SLL=4'b0001, ALU_SLT=4'b0010, ALU_SLTU=4'b0011, ALU_XOR=4'b0100, ALU_SRL=4'b0101, ALU_SRA=4'b1101, ALU_OR=4'b0110, ALU_AND=4'b0111.
  - XLEN and RA_W.
- One sub-module, alu: purely combinational, taking alu_ctrl, a and b and producing result and zero. ex_stage instantiates it and owns the pipeline and skid registers.

Test Plan:
- Reset: hold rst_n low for 3 cycles, with clk running → out_valid=0, result=0, in_ready=1.
- ALU sweep:
  - op_a=32'hFFFF_FFF0, op_b=32'h0000_0004, one beat per code, out_ready=1.
  - Expected results: add=FFFF_FFF4, sub=FFFF_FFEC, sll=FFFF_FF00, srl=0FFF_FFFF, sra=FFFF_FFFF, slt=1, sltu=0, xor=FFFF_FFF4, or=FFFF_FFF4, and=0.
  - Each result appears 1 cycle after acceptance.
- Branch:
  - sub with op_a=op_b=5, branch_in=1, branch_ne_in=0 → zero=1, branch_taken=1.
  - Same operands with branch_ne_in=1 → branch_taken=0.
- Backpressure:
  - Stream 4 beats with out_ready low for cycles 2–4 → beats emerge in order, none lost or duplicated.
  - With EX_SKID_EN, in_ready drops exactly one cycle after the skid fills.
- Flush:
  - Assert flush while out_valid=1 and in_valid=1 with reg_write_in=1 → next cycle out_valid=0 and reg_write=0, and the offered beat never appears.
- Async reset mid-stall: drop rst_n between clock edges while stalled → outputs go to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath widths, ALU control codes and the
// EX/MEM beat layout used by the execute stage.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // One EX/MEM beat: everything the memory stage needs from execute.
    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic            branch_taken;
        logic [XLEN-1:0] store_data;
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } ex_beat_t;

    // Strip side-effecting control from a beat so a flushed slot can never
    // write a register, touch memory or redirect the fetch.
    function automatic ex_beat_t kill_ctrl(input ex_beat_t b);
        ex_beat_t k;
        k              = b;
        k.branch_taken = 1'b0;
        k.reg_write    = 1'b0;
        k.mem_read     = 1'b0;
        k.mem_write    = 1'b0;
        return k;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU: decodes the 4-bit ALU control code and produces
// the result plus a zero flag. Unknown codes yield 0.
module alu
    import riscv_pkg::*;
(
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [4:0] w_shamt;

    assign w_shamt = b[4:0];

    // Select the operation named by the control code.
    always_comb begin
        // NOTE: default assignment first so every path drives result and no latch is inferred.
        result = '0;
        case (alu_ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << w_shamt;
            ALU_SRL:  result = a >> w_shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> w_shamt);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, branch resolution and the EX/MEM pipeline
// register behind a valid/ready handshake with flush.
// Build option EX_SKID_EN adds a one-entry skid buffer so in_ready is
// registered and has no combinational path from out_ready.
module ex_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] store_data_in,
    input  logic [RA_W-1:0] rd_in,
    input  logic            reg_write_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            branch_in,
    input  logic            branch_ne_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            branch_taken,
    output logic [XLEN-1:0] store_data,
    output logic [RA_W-1:0] rd,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write
);

    logic [XLEN-1:0] w_alu_result;
    logic            w_alu_zero;
    ex_beat_t        w_beat;
    ex_beat_t        r_out;
    logic            r_out_valid;

    alu u_alu (
        .alu_ctrl (alu_ctrl),
        .a        (op_a),
        .b        (op_b),
        .result   (w_alu_result),
        .zero     (w_alu_zero)
    );

    // Assemble the incoming beat: ALU outputs, resolved branch and passthroughs.
    always_comb begin
        w_beat.result       = w_alu_result;
        w_beat.zero         = w_alu_zero;
        w_beat.branch_taken = branch_in & (w_alu_zero ^ branch_ne_in);
        w_beat.store_data   = store_data_in;
        w_beat.rd           = rd_in;
        w_beat.reg_write    = reg_write_in;
        w_beat.mem_read     = mem_read_in;
        w_beat.mem_write    = mem_write_in;
    end

`ifdef EX_SKID_EN
    ex_beat_t r_skid;
    logic     r_skid_valid;
    logic     w_out_free;
    logic     w_accept;

    // Upstream sees only the skid occupancy, never out_ready directly.
    assign in_ready   = ~r_skid_valid;
    assign w_out_free = ~r_out_valid | out_ready;
    assign w_accept   = in_valid & ~r_skid_valid;

    // Output register fed from the skid first (order), else from the input;
    // a beat arriving during a stall parks in the skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= kill_ctrl(r_out);
            r_skid       <= kill_ctrl(r_skid);
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out       <= w_beat;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_beat;
            r_skid_valid <= 1'b1;
        end
    end
`else
    // Accept whenever the output slot is empty or being drained this cycle.
    assign in_ready = ~r_out_valid | out_ready;

    // Single EX/MEM register: load on accept, hold on stall, kill on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_out       <= kill_ctrl(r_out);
        end else if (in_ready) begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out <= w_beat;
            end
        end
    end
`endif

    assign out_valid    = r_out_valid;
    assign result       = r_out.result;
    assign zero         = r_out.zero;
    assign branch_taken = r_out.branch_taken;
    assign store_data   = r_out.store_data;
    assign rd           = r_out.rd;
    assign reg_write    = r_out.reg_write;
    assign mem_read     = r_out.mem_read;
    assign mem_write    = r_out.mem_write;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver pushes the expected beat on
// every accepted input; an independent monitor pops and compares on every
// output transfer.
module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] store_data_in;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        branch_in;
    logic        branch_ne_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        branch_taken;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;

    ex_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_ctrl      (alu_ctrl),
        .op_a          (op_a),
        .op_b          (op_b),
        .store_data_in (store_data_in),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .branch_in     (branch_in),
        .branch_ne_in  (branch_ne_in),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .branch_taken  (branch_taken),
        .store_data    (store_data),
        .rd            (rd),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write)
    );

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ne;
    } stim_t;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        bt;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        chk_lat;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference ALU written straight from the opcode table.
    function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (c)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << sh;
            4'b0101: return a >> sh;
            4'b1101: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'b0010: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        e.result  = alu_model(s.ctrl, s.a, s.b);
        e.zero    = (e.result == 32'd0);
        e.bt      = s.br & (e.zero ^ s.ne);
        e.sd      = s.sd;
        e.rd      = s.rd;
        e.rw      = s.rw;
        e.mr      = s.mr;
        e.mw      = s.mw;
        e.chk_lat = 1'b0;
        e.cyc     = 0;
        return e;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.ctrl = 4'($urandom_range(0, 15));
        s.a    = $urandom;
        s.b    = ($urandom_range(0, 3) == 0) ? s.a : $urandom;
        s.sd   = $urandom;
        s.rd   = 5'($urandom_range(0, 31));
        s.rw   = 1'($urandom_range(0, 1));
        s.mr   = 1'($urandom_range(0, 1));
        s.mw   = 1'($urandom_range(0, 1));
        s.br   = 1'($urandom_range(0, 1));
        s.ne   = 1'($urandom_range(0, 1));
        return s;
    endfunction

    // One cycle of stimulus. Inputs change 1 time unit after the rising edge;
    // acceptance and outputs are sampled at the falling edge.
    task automatic step(input logic v, input stim_t s, input exp_t e, input logic ordy,
                        input logic fl, output logic acc, output logic inr, output logic ov);
        stim_t d;
        d = v ? s : rand_stim();
        in_valid      = v;
        alu_ctrl      = d.ctrl;
        op_a          = d.a;
        op_b          = d.b;
        store_data_in = d.sd;
        rd_in         = d.rd;
        reg_write_in  = d.rw;
        mem_read_in   = d.mr;
        mem_write_in  = d.mw;
        branch_in     = d.br;
        branch_ne_in  = d.ne;
        out_ready     = ordy;
        flush         = fl;
        @(negedge clk);
        inr = in_ready;
        ov  = out_valid;
        acc = v && in_ready && !fl;
        if (acc) begin
            e.cyc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        stim_t s;
        exp_t  e;
        logic  a, r, o;
        s = '0;
        e = '0;
        step(1'b0, s, e, ordy, 1'b0, a, r, o);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 50) begin
            idle(1'b1);
            n++;
        end
        check(name, 64'(q.size()), 64'd0);
    endtask

    // Monitor: every output transfer must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_beat", 64'(out_valid), 64'd0);
            end else begin
                mon_e = q.pop_front();
                check("result",       64'(result),       64'(mon_e.result));
                check("zero",         64'(zero),         64'(mon_e.zero));
                check("branch_taken", 64'(branch_taken), 64'(mon_e.bt));
                check("store_data",   64'(store_data),   64'(mon_e.sd));
                check("rd",           64'(rd),           64'(mon_e.rd));
                check("ctrl_bits",    64'({reg_write, mem_read, mem_write}),
                                      64'({mon_e.rw, mon_e.mr, mon_e.mw}));
                if (mon_e.chk_lat) check("latency", 64'(cyc), 64'(mon_e.cyc + 1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [3:0]  sweep_code [12] = '{4'b0000, 4'b1000, 4'b0001, 4'b0101, 4'b1101, 4'b0010,
                                     4'b0011, 4'b0100, 4'b0110, 4'b0111, 4'b1111, 4'b1001};
    logic [31:0] sweep_res  [12] = '{32'hFFFF_FFF4, 32'hFFFF_FFEC, 32'hFFFF_FF00, 32'h0FFF_FFFF,
                                     32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFF4,
                                     32'hFFFF_FFF4, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    initial begin
        stim_t s;
        exp_t  e;
        logic  acc, inr, ov;
        logic  prev_fill;
        int    idx, n;

        rst_n = 1'b0;
        in_valid = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0; store_data_in = '0; rd_in = '0;
        reg_write_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        branch_in = 1'b0; branch_ne_in = 1'b0; flush = 1'b0; out_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    64'(result),    64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_ctrl",      64'({reg_write, mem_read, mem_write, branch_taken}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU sweep with fixed operands, back-to-back beats.
        for (int i = 0; i < 12; i++) begin
            s = '0;
            s.ctrl = sweep_code[i];
            s.a    = 32'hFFFF_FFF0;
            s.b    = 32'h0000_0004;
            s.sd   = 32'(i) * 32'h0101_0101;
            s.rd   = 5'(i + 1);
            s.rw   = 1'b1;
            e = model(s);
            e.result  = sweep_res[i];
            e.zero    = (sweep_res[i] == 32'd0);
            e.bt      = 1'b0;
            e.chk_lat = 1'b1;
            step(1'b1, s, e, 1'b1, 1'b0, acc, inr, ov);
            check("sweep_accept", 64'(acc), 64'd1);
        end
        drain("sweep_drain");

        // Branch resolution: beq taken, bne not taken on equal operands.
        for (int i = 0; i < 2; i++) begin
            s = '0;
            s.ctrl = 4'b1000;
            s.a    = 32'd5;
            s.b    = 32'd5;
            s.br   = 1'b1;
            s.ne   = 1'(i);
            e = model(s);
            e.zero    = 1'b1;
            e.bt      = (i == 0);
            e.chk_lat = 1'b1;
            step(1'b1, s, e, 1'b1, 1'b0, acc, inr, ov);
        end
        drain("branch_drain");

        // Backpressure: four beats with out_ready low during cycles 2-4.
        idx = 0;
        n = 1;
        prev_fill = 1'b0;
        while (idx < 4 && n <= 20) begin
            s = rand_stim();
            s.rd = 5'(idx + 20);
            e = model(s);
            step(1'b1, s, e, !(n >= 2 && n <= 4), 1'b0, acc, inr, ov);
`ifdef EX_SKID_EN
            if (prev_fill) check("skid_full_in_ready", 64'(inr), 64'd0);
            prev_fill = ov && (n >= 2 && n <= 4) && acc;
`else
            if (ov && (n >= 2 && n <= 4)) check("stall_in_ready", 64'(inr), 64'd0);
`endif
            if (acc) idx++;
            n++;
        end
        check("bp_all_accepted", 64'(idx), 64'd4);
        drain("bp_drain");

        // Flush while holding a stalled beat and offering a new one.
        for (int i = 0; i < 2; i++) begin
            s = rand_stim();
            s.rw = 1'b1; s.mr = 1'b1; s.mw = 1'b1;
            s.ctrl = 4'b1000; s.a = 32'd9; s.b = 32'd9; s.br = 1'b1; s.ne = 1'b0;
            e = model(s);
            step(1'b1, s, e, 1'b0, 1'b0, acc, inr, ov);
        end
        check("flush_pre_valid", 64'(out_valid), 64'd1);
        q.delete();
        s = rand_stim();
        s.rw = 1'b1;
        e = model(s);
        step(1'b1, s, e, 1'b0, 1'b1, acc, inr, ov);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_ctrl", 64'({reg_write, mem_read, mem_write, branch_taken}), 64'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            check("flush_no_beat", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset between edges while stalled.
        for (int i = 0; i < 2; i++) begin
            s = rand_stim();
            s.ctrl = 4'b0000; s.a = 32'd1; s.b = 32'd2; s.rw = 1'b1;
            e = model(s);
            step(1'b1, s, e, 1'b0, 1'b0, acc, inr, ov);
        end
        @(negedge clk);
        #2;
        check("pre_areset_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("areset_out_valid", 64'(out_valid), 64'd0);
        check("areset_result",    64'(result),    64'd0);
        check("areset_ctrl",      64'({reg_write, rd}), 64'd0);
        check("areset_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("areset_no_beat", 64'(out_valid), 64'd0);
        end

        // Randomized traffic with random gaps and backpressure.
        for (int i = 0; i < 400; i++) begin
            s = rand_stim();
            e = model(s);
            step($urandom_range(0, 3) != 0, s, e, $urandom_range(0, 3) != 0, 1'b0, acc, inr, ov);
        end
        drain("random_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
